// File: rtl/fetch_queue_if.sv
// fetch_queue_if
// Groups every signal of the fetch queue except clock and reset.
//   Memory side : imem_req/imem_addr out, imem_ack/imem_rdata in.
//   Decode side : inst_valid/inst/inst_pc out, inst_ready in.
//   Control     : redirect_valid/redirect_pc in (taken branch or jump).
// The master modport is the fetch queue; the slave modport is its environment
// (instruction memory, decoder and branch unit).
interface fetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        input  redirect_valid,
        input  redirect_pc,
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        output redirect_valid,
        output redirect_pc,
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction fetch unit: issues sequential word reads to instruction memory
// (one outstanding at a time) and buffers returned words with their addresses
// in a DEPTH-entry FIFO for the decoder. A redirect flushes the FIFO and
// restarts fetching at the new address; a read already in flight is allowed
// to complete and its data is thrown away.
// Ports:
//   i_clk   : clock, all state updates on the rising edge
//   i_reset : synchronous active-low reset
//   io_fq   : fetch_queue_if master (memory, decode and redirect signals)
// Parameters:
//   RESET_PC : first fetch address after reset
//   DEPTH    : FIFO entries, power of two and >= 2
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    fetch_queue_if.master io_fq
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [31:0]        r_fpc;
    logic [31:0]        w_fpc_d;
    logic [31:0]        r_req_addr;
    logic [31:0]        r_inst_mem [DEPTH];
    logic [31:0]        r_pc_mem   [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_valid;
    logic               w_req;
    logic [31:0]        w_addr;
    logic               w_push;
    logic               w_pop;
    logic               w_redirect;

    assign w_redirect = io_fq.redirect_valid;
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid & io_fq.inst_ready & ~w_redirect;

    // Next-state / request logic. An issue from StIdle behaves as StWait in the
    // same cycle, so a same-cycle ack completes the fetch without visiting StWait.
    always_comb begin
        w_state_d = r_state;
        w_fpc_d   = r_fpc;
        w_req     = 1'b0;
        w_addr    = r_req_addr;
        w_push    = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_addr = r_fpc;
                if (!w_redirect && !w_full) begin
                    w_req = 1'b1;
                    if (io_fq.imem_ack) begin
                        w_push  = 1'b1;
                        w_fpc_d = r_fpc + 32'd4;
                    end else begin
                        w_state_d = StWait;
                    end
                end
            end
            StWait: begin
                w_req = 1'b1;
                if (io_fq.imem_ack) begin
                    w_state_d = StIdle;
                    if (!w_redirect) begin
                        w_push  = 1'b1;
                        w_fpc_d = r_req_addr + 32'd4;
                    end
                end else if (w_redirect) begin
                    w_state_d = StDiscard;
                end
            end
            StDiscard: begin
                // Old request stays on the bus until memory answers; data is dropped.
                w_req = 1'b1;
                if (io_fq.imem_ack) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
        if (w_redirect) begin
            w_fpc_d = {io_fq.redirect_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_fpc      <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state <= w_state_d;
            r_fpc   <= w_fpc_d;
            if (r_state == StIdle && w_state_d == StWait) begin
                r_req_addr <= r_fpc;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_redirect) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PTR_W'(w_push);
            r_rptr  <= r_rptr + PTR_W'(w_pop);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge i_clk) begin
        if (i_reset && w_push) begin
            r_inst_mem[r_wptr] <= io_fq.imem_rdata;
            r_pc_mem[r_wptr]   <= w_addr;
        end
    end

    // Reset is synchronous, so outputs are gated explicitly while it is held.
    always_comb begin
        io_fq.imem_req   = i_reset & w_req;
        io_fq.imem_addr  = i_reset ? w_addr : RESET_PC;
        io_fq.inst_valid = i_reset & w_valid;
        io_fq.inst       = i_reset ? r_inst_mem[r_rptr] : 32'h0;
        io_fq.inst_pc    = i_reset ? r_pc_mem[r_rptr] : 32'h0;
    end
endmodule
